// File: rtl/serial_frame_rx.sv
// Serial frame receiver: hunts for a sync pattern, then shifts in
// WIDTH data bits MSB-first plus one parity bit.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   d_in       serial bit from the upstream flip-flop Q
//   bit_en     sample d_in at this edge; all state holds when low
//   data_out   last good frame word, MSB = first data bit received
//   data_valid one-cycle pulse, data_out just updated
//   parity_err one-cycle pulse, frame discarded for bad parity
//   busy       high while in DATA or PARITY
module serial_frame_rx #(
    parameter int                    WIDTH        = 8,
    parameter int                    SYNC_LEN     = 4,
    parameter logic [SYNC_LEN-1:0]   SYNC_PATTERN = 4'b1011,
    parameter bit                    ODD_PARITY   = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             d_in,
    input  logic             bit_en,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             parity_err,
    output logic             busy
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        HUNT,
        DATA,
        PARITY
    } state_t;

    state_t              state;
    // Holds the previous SYNC_LEN-1 bits; together with d_in this
    // forms the full SYNC_LEN-bit window after the shift.
    logic [SYNC_LEN-2:0] sync_sr;
    logic [WIDTH-1:0]    data_sr;
    logic [CW-1:0]       bit_cnt;

    logic [SYNC_LEN-1:0] sync_next;
    logic                par_pass;

    assign sync_next = {sync_sr, d_in};
    assign par_pass  = ((^data_sr) ^ d_in) == ODD_PARITY;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= HUNT;
            sync_sr    <= '0;
            data_sr    <= '0;
            bit_cnt    <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            busy       <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            if (bit_en) begin
                unique case (state)
                    HUNT: begin
                        sync_sr <= sync_next[SYNC_LEN-2:0];
                        if (sync_next == SYNC_PATTERN) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                            busy    <= 1'b1;
                        end
                    end
                    DATA: begin
                        data_sr <= {data_sr[WIDTH-2:0], d_in};
                        bit_cnt <= bit_cnt + CW'(1);
                        if (bit_cnt == CW'(WIDTH - 1)) begin
                            state <= PARITY;
                        end
                    end
                    PARITY: begin
                        if (par_pass) begin
                            data_out   <= data_sr;
                            data_valid <= 1'b1;
                        end else begin
                            parity_err <= 1'b1;
                        end
                        // Frame bits never seed the next sync search.
                        sync_sr <= '0;
                        state   <= HUNT;
                        busy    <= 1'b0;
                    end
                    default: begin
                        state <= HUNT;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
